// File: rtl/time_entry_loader_pkg.sv
// Shared timer definitions: state encoding, key codes, digit geometry and the
// MM:SS entry buffer payload.
package time_entry_loader_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned COUNT_W    = 3;
    localparam int unsigned MAX_DIGITS = 4;

    localparam logic [DIGIT_W-1:0] KEY_START    = 4'hA;
    localparam logic [DIGIT_W-1:0] KEY_CANCEL   = 4'hB;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

    // 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Entry buffer, most significant digit first so a left shift is a concat.
    typedef struct packed {
        logic [DIGIT_W-1:0] min_tens;
        logic [DIGIT_W-1:0] min_units;
        logic [DIGIT_W-1:0] sec_tens;
        logic [DIGIT_W-1:0] sec_units;
    } entry_t;

    function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
        return code <= DIGIT_W'(9);
    endfunction

endpackage

// File: rtl/time_entry_loader_if.sv
// Keypad/timer-chain bus of the entry loader.
//   master: keypad encoder and counter chain (drive keys and timer_done)
//   slave : the loader (drives buffered digits, loadn, enable, status)
interface time_entry_loader_if;
    import time_entry_loader_pkg::*;

    logic               key_pressed;
    logic [DIGIT_W-1:0] key_code;
    logic               timer_done;
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_units;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_units;
    logic               loadn;
    logic               enable;
    logic [COUNT_W-1:0] digit_count;
    logic               entry_error;

    modport master (
        output key_pressed, key_code, timer_done,
        input  min_tens, min_units, sec_tens, sec_units,
        input  loadn, enable, digit_count, entry_error
    );

    modport slave (
        input  key_pressed, key_code, timer_done,
        output min_tens, min_units, sec_tens, sec_units,
        output loadn, enable, digit_count, entry_error
    );
endinterface

// File: rtl/time_entry_loader_key_edge_detect.sv
// Rising-edge detector for a synchronous button level.
//   clock, clear : clock and async active-high reset
//   level        : button level
//   pulse_c      : one-cycle pulse on the first cycle the level is seen high
// After reset the detector stays disarmed until the level has been seen low,
// so a button held through reset does not produce a spurious event.
module key_edge_detect (
    input  logic clock,
    input  logic clear,
    input  logic level,
    output logic pulse_c
);
    logic key_prev;
    logic armed_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            key_prev <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            key_prev <= level;
            if (!level) armed_q <= 1'b1;
        end
    end

    assign pulse_c = level & ~key_prev & armed_q;
endmodule

// File: rtl/time_entry_loader.sv
// Keypad front end of the microwave timer: collects BCD digits into an MM:SS
// buffer, validates on START, loads the down-counters and enables counting.
//   clock, clear : clock and async active-high reset
//   bus (slave)  : key_pressed/key_code/timer_done in; digits, loadn, enable,
//                  digit_count, entry_error out (all registered)
module time_entry_loader
    import time_entry_loader_pkg::*;
(
    input  logic                  clock,
    input  logic                  clear,
    time_entry_loader_if.slave    bus
);
    state_t             state_q, state_d;
    entry_t             entry_q, entry_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               loadn_q, loadn_d;
    logic               enable_q, enable_d;
    logic               error_q, error_d;
    logic               key_ev;
    logic               start_ok;

    key_edge_detect u_key_edge (
        .clock   (clock),
        .clear   (clear),
        .level   (bus.key_pressed),
        .pulse_c (key_ev)
    );

    // START is legal only for a non-empty buffer with a valid seconds-tens digit.
    assign start_ok = (entry_q != '0) && (entry_q.sec_tens <= SEC_TENS_MAX);

    // State and registered outputs.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            entry_q  <= '0;
            count_q  <= '0;
            loadn_q  <= 1'b1;
            enable_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            count_q  <= count_d;
            loadn_q  <= loadn_d;
            enable_q <= enable_d;
            error_q  <= error_d;
        end
    end

    // Next state, buffer updates and next output values.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        count_d = count_q;
        error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_ev) begin
                    if (is_digit(bus.key_code)) begin
                        if (count_q < COUNT_W'(MAX_DIGITS)) begin
                            entry_d = {entry_q.min_units, entry_q.sec_tens,
                                       entry_q.sec_units, bus.key_code};
                            count_d = count_q + COUNT_W'(1);
                        end
                    end else if (bus.key_code == KEY_CANCEL) begin
                        entry_d = '0;
                        count_d = '0;
                    end else if (bus.key_code == KEY_START) begin
                        if (start_ok) state_d = ST_LOAD;
                        else          error_d = 1'b1;
                    end
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.timer_done || (key_ev && bus.key_code == KEY_CANCEL)) begin
                    state_d = ST_IDLE;
                    entry_d = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                entry_d = '0;
                count_d = '0;
            end
        endcase

        loadn_d  = (state_d != ST_LOAD);
        enable_d = (state_d == ST_RUN);
    end

    assign bus.min_tens    = entry_q.min_tens;
    assign bus.min_units   = entry_q.min_units;
    assign bus.sec_tens    = entry_q.sec_tens;
    assign bus.sec_units   = entry_q.sec_units;
    assign bus.digit_count = count_q;
    assign bus.loadn       = loadn_q;
    assign bus.enable      = enable_q;
    assign bus.entry_error = error_q;
endmodule

// File: doc/time_entry_loader.md
Name: time_entry_loader

Overview:
- Keypad-side front end of the microwave timer. It collects BCD digits into an MM:SS entry buffer and validates the entry on START.
- On a valid START it drives the parallel data_in/loadn load into the four BCD down-counter digit stages, then holds them counting via enable.
- It returns to entry mode when the timer chain reports done, or on CANCEL.

Parameters:
- KEY_START, 4'hA, key_code value that requests start.
- KEY_CANCEL, 4'hB, key_code value that cancels or clears.
- SEC_TENS_MAX, 5, largest legal seconds-tens digit.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- clear  input  1  asynchronous, active-high reset.
- key_pressed  input  1  level from keypad encoder, synchronous to clock.
- key_code  input  4  0-9 are digits; KEY_START and KEY_CANCEL are commands; other values are ignored.
- timer_done  input  1  high when the whole counter chain has reached 00:00.
- min_tens  output  4  buffered minutes-tens digit.
- min_units  output  4  buffered minutes-units digit.
- sec_tens  output  4  buffered seconds-tens digit.
- sec_units  output  4  buffered seconds-units digit.
- loadn  output  1  active-low parallel load strobe to the counters.
- enable  output  1  count enable to the counters.
- digit_count  output  3  number of digits entered, 0..4.
- entry_error  output  1  one-cycle pulse when START is rejected.

Behaviour:
- Reset: clear=1 forces state=IDLE, all four digits=0, digit_count=0, loadn=1, enable=0, entry_error=0, key_prev=0. Reset takes effect immediately and from any state, including mid-LOAD or mid-RUN.
- Key event: key_ev = key_pressed & ~key_prev. key_prev is registered every clock. A held key produces exactly one event. Each event is acted on at the same posedge that first sees key_ev=1.
- States: IDLE (entry), LOAD, RUN. All outputs are registered or decoded from registered state only; no combinational path from inputs to loadn or enable.
- IDLE, digit event with digit_count<4: shift left one digit (min_tens<=min_units, min_units<=sec_tens, sec_tens<=sec_units, sec_units<=key_code); digit_count+1.
- IDLE, digit event with digit_count==4: ignored; buffer and count unchanged.
- IDLE, KEY_CANCEL: all digits=0, digit_count=0.
- IDLE, KEY_START: rejected if the buffer is all zeros or sec_tens>SEC_TENS_MAX. On reject, entry_error=1 for exactly one cycle, buffer is kept, and state stays IDLE. Otherwise next state is LOAD.
- IDLE, undefined key codes: ignored.
- LOAD: lasts exactly one cycle. loadn=0, enable=0 (the counters give enable priority over load). Digits are held stable. All key events are ignored. Next state is RUN.
- RUN: loadn=1, enable=1, digits held.
- RUN, timer_done=1 or KEY_CANCEL event: next state IDLE with digits=0, digit_count=0, enable=0 from the following cycle. If both occur in the same cycle, the result is the same single transition.
- RUN, digit and START events: ignored.
- RUN, timer_done sampled in the first RUN cycle: honoured as normal. The counters may not yet reflect the load; upstream guarantees timer_done is low for at least one cycle after load.
- loadn is high in every state except LOAD.
- entry_error is 0 except for the single reject cycle.
- digit_count saturates at 4; it never wraps.

Decomposition:
- Shared timer package holds:
  - state encoding: IDLE=2'd0, LOAD=2'd1, RUN=2'd2; 2'd3 is illegal and recovers to IDLE;
  - key constants KEY_START and KEY_CANCEL;
  - SEC_TENS_MAX;
  - BCD digit width of 4.
- One natural sub-module: key_edge_detect (key_prev register plus rising-edge pulse), reusable for the door and start buttons.

Test Plan:
- Reset release, then press digits 1,3,0 (each held 3 cycles) and START -> digits 0,1,3,0 and digit_count=3. loadn=0 for exactly one cycle; enable=1 from the next cycle.
- Enter 9,9,9,9,7 -> digits 9,9,9,9 and digit_count=4; the fifth key is ignored. START -> entry_error pulses for 1 cycle, state stays IDLE, buffer unchanged.
- Empty buffer, START -> entry_error=1 for one cycle; loadn stays 1.
- Load 0,0,4,5, then raise timer_done in RUN -> next cycle enable=0, all digits=0, digit_count=0, and state IDLE. New digits are accepted afterwards.
- In RUN, press digit 7 and START -> no change. Press CANCEL in the same cycle as timer_done -> single return to IDLE with a cleared buffer.
- Assert clear during LOAD -> loadn=1, enable=0, and digits=0 immediately and asynchronously; after release, key_pressed already high yields no event until it drops and rises again.
